i2c_cmd_arbiter: RTL and testbench



---
 rtl/i2c_cmd_arbiter_if.sv | 29 ++
 rtl/i2c_cmd_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_i2c_cmd_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cmd_arbiter_if.sv
// Bus bundle between the two command sources, the arbiter and the I2C_Controller.
// The master side is the arbiter; the slave side is the requesters plus the controller.
interface i2c_cmd_arbiter_if;
  logic        req0;
  logic [23:0] data0;
  logic        req1;
  logic [23:0] data1;
  logic        done0;
  logic        err0;
  logic        done1;
  logic        err1;
  logic [1:0]  gnt;
  logic [23:0] mi2c_data;
  logic        mi2c_go;
  logic        mi2c_end;
  logic [2:0]  mi2c_ack;
  logic [2:0]  last_ack;
  logic        busy;

  modport master (
    input  req0, data0, req1, data1, mi2c_end, mi2c_ack,
    output done0, err0, done1, err1, gnt, mi2c_data, mi2c_go, last_ack, busy
  );

  modport slave (
    output req0, data0, req1, data1, mi2c_end, mi2c_ack,
    input  done0, err0, done1, err1, gnt, mi2c_data, mi2c_go, last_ack, busy
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller between two 24-bit command sources,
// with NACK retry, per-issue timeout and an enforced idle gap between GO pulses.
module i2c_cmd_arbiter #(
  parameter int unsigned MAX_RETRY   = 2,
  parameter logic [15:0] TIMEOUT_CYC = 16'd2000,
  parameter logic [3:0]  GAP_CYC     = 4'd2
) (
  input logic               clk_i2c,
  input logic               reset,
  i2c_cmd_arbiter_if.master bus
);

  localparam logic [7:0] RETRY_LIM = MAX_RETRY[7:0];

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    CHECK     = 3'd4,
    GAP       = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [23:0] data_q, data_d;
  logic        go_q, go_d;
  logic [2:0]  ack_q, ack_d;
  logic [7:0]  retry_q, retry_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic        pend_q, pend_d;
  logic        last_q, last_d;
  logic        done0_q, done0_d;
  logic        err0_q, err0_d;
  logic        done1_q, done1_d;
  logic        err1_q, err1_d;
  logic        timeout_hit;

  assign timeout_hit = (TIMEOUT_CYC != 16'd0) && (tcnt_q == TIMEOUT_CYC);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    go_d    = go_q;
    ack_d   = ack_q;
    retry_d = retry_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    pend_d  = pend_q;
    last_d  = last_q;
    done0_d = 1'b0;
    err0_d  = 1'b0;
    done1_d = 1'b0;
    err1_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // last_q names the requester served most recently; the other one wins a tie
        if (bus.req0 && (!bus.req1 || last_q)) begin
          gnt_d   = 2'b01;
          data_d  = bus.data0;
          retry_d = 8'd0;
          state_d = ISSUE;
        end else if (bus.req1) begin
          gnt_d   = 2'b10;
          data_d  = bus.data1;
          retry_d = 8'd0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        go_d    = 1'b1;
        tcnt_d  = 16'd0;
        pend_d  = 1'b0;
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY, WAIT_DONE: begin
        if (timeout_hit) begin
          err0_d  = gnt_q[0];
          err1_d  = gnt_q[1];
          last_d  = gnt_q[1];
          go_d    = 1'b0;
          gcnt_d  = 4'd0;
          state_d = GAP;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
          // END must be seen low before its rising edge counts as completion
          if (state_q == WAIT_BUSY) begin
            if (!bus.mi2c_end) state_d = WAIT_DONE;
          end else if (bus.mi2c_end) begin
            ack_d   = bus.mi2c_ack;
            go_d    = 1'b0;
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        gcnt_d  = 4'd0;
        state_d = GAP;
        if (ack_q == 3'b000) begin
          done0_d = gnt_q[0];
          done1_d = gnt_q[1];
          last_d  = gnt_q[1];
        end else if (retry_q < RETRY_LIM) begin
          retry_d = retry_q + 8'd1;
          pend_d  = 1'b1;
        end else begin
          err0_d  = gnt_q[0];
          err1_d  = gnt_q[1];
          last_d  = gnt_q[1];
        end
      end

      GAP: begin
        if ((gcnt_q + 4'd1) >= GAP_CYC) begin
          if (pend_q) begin
            state_d = ISSUE;
          end else begin
            gnt_d   = 2'b00;
            state_d = IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end

      default: begin
        gnt_d   = 2'b00;
        go_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i2c) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      data_q  <= 24'd0;
      go_q    <= 1'b0;
      ack_q   <= 3'b000;
      retry_q <= 8'd0;
      tcnt_q  <= 16'd0;
      gcnt_q  <= 4'd0;
      pend_q  <= 1'b0;
      last_q  <= 1'b1;
      done0_q <= 1'b0;
      err0_q  <= 1'b0;
      done1_q <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      go_q    <= go_d;
      ack_q   <= ack_d;
      retry_q <= retry_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      done0_q <= done0_d;
      err0_q  <= err0_d;
      done1_q <= done1_d;
      err1_q  <= err1_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.mi2c_data = data_q;
  assign bus.mi2c_go   = go_q;
  assign bus.last_ack  = ack_q;
  assign bus.done0     = done0_q;
  assign bus.err0      = err0_q;
  assign bus.done1     = done1_q;
  assign bus.err1      = err1_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a behavioural I2C_Controller model
// (configurable stale END, transfer length, NACK count and stuck END).
module tb_i2c_cmd_arbiter;
  logic clk_i2c;
  logic reset;

  i2c_cmd_arbiter_if bus();

  i2c_cmd_arbiter #(
    .MAX_RETRY   (2),
    .TIMEOUT_CYC (16'd50),
    .GAP_CYC     (4'd2)
  ) dut (
    .clk_i2c (clk_i2c),
    .reset   (reset),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // controller model knobs, written only by the test sequence
  int m_stale    = 0;
  int m_len      = 30;
  int nack_until = 0;
  bit m_stuck    = 1'b0;

  // written only by the model / monitor
  int xfer_cnt  = 0;
  int go_rises  = 0;
  int both_cnt  = 0;
  int low_run   = 0;
  int gap_q[$];

  initial begin
    clk_i2c = 1'b0;
    forever #5 clk_i2c = ~clk_i2c;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : ctrl_model
    logic prev;
    prev          = 1'b0;
    bus.mi2c_end  = 1'b1;
    bus.mi2c_ack  = 3'b000;
    forever begin
      @(negedge clk_i2c);
      if (bus.mi2c_go && !prev && !m_stuck) begin
        repeat (m_stale) @(negedge clk_i2c);
        bus.mi2c_end = 1'b0;
        repeat (m_len) @(negedge clk_i2c);
        bus.mi2c_ack = (xfer_cnt < nack_until) ? 3'b010 : 3'b000;
        xfer_cnt++;
        bus.mi2c_end = 1'b1;
      end
      prev = bus.mi2c_go;
    end
  end

  initial begin : go_monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_i2c);
      if (bus.mi2c_go) begin
        if (!prev) begin
          go_rises++;
          gap_q.push_back(low_run);
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      if ((bus.done0 && bus.err0) || (bus.done1 && bus.err1)) both_cnt++;
      prev = bus.mi2c_go;
    end
  end

  task automatic wait_go(input int budget, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < budget) begin
      @(negedge clk_i2c);
      cyc++;
      if (bus.mi2c_go) hit = 1'b1;
    end
    if (!hit) cyc = -1;
  endtask

  task automatic wait_pulse(input int budget, output int cyc, output logic [3:0] p);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    p   = 4'b0000;
    while (!hit && cyc < budget) begin
      @(negedge clk_i2c);
      cyc++;
      if (bus.done0 || bus.err0 || bus.done1 || bus.err1) begin
        p   = {bus.done0, bus.err0, bus.done1, bus.err1};
        hit = 1'b1;
      end
    end
    if (!hit) cyc = -1;
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk_i2c);
    reset    = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] p;
    repeat (3) @(negedge clk_i2c);
    p = {bus.done0, bus.err0, bus.done1, bus.err1};
    vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
    vectors++; if (bus.mi2c_go !== 1'b0) begin miscompares++; $display("FAIL reset_go: got %b want 0", bus.mi2c_go); end
    vectors++; if (bus.mi2c_data !== 24'h0) begin miscompares++; $display("FAIL reset_data: got %h want 000000", bus.mi2c_data); end
    vectors++; if (bus.last_ack !== 3'b000) begin miscompares++; $display("FAIL reset_last_ack: got %b want 000", bus.last_ack); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (p !== 4'b0000) begin miscompares++; $display("FAIL reset_pulses: got %b want 0000", p); end
    reset = 1'b0;
    @(negedge clk_i2c);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    int cyc, r0;
    logic [3:0] p;
    r0 = go_rises;
    bus.data0 = 24'h341E00;
    bus.req0  = 1'b1;
    @(negedge clk_i2c);
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL single_gnt: got %b want 01", bus.gnt); end
    vectors++; if (bus.mi2c_data !== 24'h341E00) begin miscompares++; $display("FAIL single_data: got %h want 341e00", bus.mi2c_data); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    wait_go(10, cyc);
    vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL single_go_latency: got %0d want 1", cyc); end
    wait_pulse(200, cyc, p);
    bus.req0 = 1'b0;
    vectors++; if (cyc !== 32) begin miscompares++; $display("FAIL single_done_latency: got %0d want 32", cyc); end
    vectors++; if (p !== 4'b1000) begin miscompares++; $display("FAIL single_pulse: got %b want 1000", p); end
    vectors++; if (bus.last_ack !== 3'b000) begin miscompares++; $display("FAIL single_last_ack: got %b want 000", bus.last_ack); end
    vectors++; if (bus.mi2c_go !== 1'b0) begin miscompares++; $display("FAIL single_go_low: got %b want 0", bus.mi2c_go); end
    @(negedge clk_i2c);
    p = {bus.done0, bus.err0, bus.done1, bus.err1};
    vectors++; if (p !== 4'b0000) begin miscompares++; $display("FAIL single_pulse_width: got %b want 0000", p); end
    @(negedge clk_i2c);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
    vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL single_gnt_end: got %b want 00", bus.gnt); end
    vectors++; if (go_rises - r0 !== 1) begin miscompares++; $display("FAIL single_go_count: got %0d want 1", go_rises - r0); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [3:0] p, exp_p;
    logic [1:0] exp_g;
    do_reset();
    bus.data0 = 24'h340C00;
    bus.data1 = 24'h340812;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    @(negedge clk_i2c);
    vectors++; if (bus.gnt !== 2'b01) begin miscompares++; $display("FAIL both_first_gnt: got %b want 01", bus.gnt); end
    vectors++; if (bus.mi2c_data !== 24'h340C00) begin miscompares++; $display("FAIL both_first_data: got %h want 340c00", bus.mi2c_data); end
    wait_pulse(200, cyc, p);
    bus.req0 = 1'b0;
    vectors++; if (p !== 4'b1000) begin miscompares++; $display("FAIL both_first_pulse: got %b want 1000", p); end
    wait_pulse(200, cyc, p);
    bus.req1 = 1'b0;
    vectors++; if (p !== 4'b0010) begin miscompares++; $display("FAIL both_second_pulse: got %b want 0010", p); end
    vectors++; if (bus.gnt !== 2'b10) begin miscompares++; $display("FAIL both_second_gnt: got %b want 10", bus.gnt); end
    vectors++; if (bus.mi2c_data !== 24'h340812) begin miscompares++; $display("FAIL both_second_data: got %h want 340812", bus.mi2c_data); end
    repeat (3) @(negedge clk_i2c);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_p = (i % 2 == 0) ? 4'b1000 : 4'b0010;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_pulse(200, cyc, p);
      if (i == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      vectors++; if (p !== exp_p) begin miscompares++; $display("FAIL fair_pulse[%0d]: got %b want %b", i, p, exp_p); end
      vectors++; if (bus.gnt !== exp_g) begin miscompares++; $display("FAIL fair_gnt[%0d]: got %b want %b", i, bus.gnt, exp_g); end
    end
    repeat (3) @(negedge clk_i2c);
  endtask

  task automatic test_retry();
    int cyc, r0, g0, gap1, gap2;
    logic [3:0] p;
    r0 = go_rises;
    g0 = gap_q.size();
    nack_until = xfer_cnt + 2;
    bus.data1 = 24'h340A05;
    bus.req1  = 1'b1;
    wait_pulse(400, cyc, p);
    bus.req1 = 1'b0;
    gap1 = (gap_q.size() > g0 + 1) ? gap_q[g0 + 1] : -1;
    gap2 = (gap_q.size() > g0 + 2) ? gap_q[g0 + 2] : -1;
    vectors++; if (p !== 4'b0010) begin miscompares++; $display("FAIL retry_pulse: got %b want 0010", p); end
    vectors++; if (go_rises - r0 !== 3) begin miscompares++; $display("FAIL retry_go_count: got %0d want 3", go_rises - r0); end
    vectors++; if (!(gap1 >= 4)) begin miscompares++; $display("FAIL retry_gap1: got %0d want >=4", gap1); end
    vectors++; if (!(gap2 >= 4)) begin miscompares++; $display("FAIL retry_gap2: got %0d want >=4", gap2); end
    vectors++; if (bus.last_ack !== 3'b000) begin miscompares++; $display("FAIL retry_last_ack: got %b want 000", bus.last_ack); end
    repeat (3) @(negedge clk_i2c);

    r0 = go_rises;
    nack_until = xfer_cnt + 1000;
    bus.req1 = 1'b1;
    wait_pulse(400, cyc, p);
    bus.req1 = 1'b0;
    vectors++; if (p !== 4'b0001) begin miscompares++; $display("FAIL nack_pulse: got %b want 0001", p); end
    vectors++; if (go_rises - r0 !== 3) begin miscompares++; $display("FAIL nack_go_count: got %0d want 3", go_rises - r0); end
    vectors++; if (bus.last_ack !== 3'b010) begin miscompares++; $display("FAIL nack_last_ack: got %b want 010", bus.last_ack); end
    nack_until = 0;
    repeat (3) @(negedge clk_i2c);
  endtask

  task automatic test_timeout();
    int cyc, r0;
    logic [3:0] p;
    m_stuck   = 1'b1;
    r0        = go_rises;
    bus.data0 = 24'h340E4A;
    bus.req0  = 1'b1;
    wait_go(10, cyc);
    wait_pulse(200, cyc, p);
    bus.req0 = 1'b0;
    vectors++; if (cyc !== 51) begin miscompares++; $display("FAIL timeout_latency: got %0d want 51", cyc); end
    vectors++; if (p !== 4'b0100) begin miscompares++; $display("FAIL timeout_pulse: got %b want 0100", p); end
    vectors++; if (bus.mi2c_go !== 1'b0) begin miscompares++; $display("FAIL timeout_go: got %b want 0", bus.mi2c_go); end
    repeat (2) @(negedge clk_i2c);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL timeout_idle: got busy %b want 0", bus.busy); end
    vectors++; if (go_rises - r0 !== 1) begin miscompares++; $display("FAIL timeout_go_count: got %0d want 1", go_rises - r0); end
    m_stuck = 1'b0;
    repeat (2) @(negedge clk_i2c);
  endtask

  task automatic test_stale_end();
    int cyc;
    logic [3:0] p;
    m_stale   = 3;
    bus.data0 = 24'h341201;
    bus.req0  = 1'b1;
    wait_go(10, cyc);
    wait_pulse(200, cyc, p);
    bus.req0 = 1'b0;
    vectors++; if (cyc !== 35) begin miscompares++; $display("FAIL stale_latency: got %0d want 35", cyc); end
    vectors++; if (p !== 4'b1000) begin miscompares++; $display("FAIL stale_pulse: got %b want 1000", p); end
    m_stale = 0;
    repeat (3) @(negedge clk_i2c);
  endtask

  task automatic test_reset_mid();
    int cyc, npulse;
    logic [3:0] p;
    bus.data0 = 24'h340C07;
    bus.req0  = 1'b1;
    wait_go(10, cyc);
    repeat (10) @(negedge clk_i2c);
    vectors++; if (bus.mi2c_go !== 1'b1) begin miscompares++; $display("FAIL mid_go_before: got %b want 1", bus.mi2c_go); end
    reset    = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk_i2c);
    reset = 1'b0;
    p = {bus.done0, bus.err0, bus.done1, bus.err1};
    vectors++; if (bus.mi2c_go !== 1'b0) begin miscompares++; $display("FAIL mid_go: got %b want 0", bus.mi2c_go); end
    vectors++; if (bus.gnt !== 2'b00) begin miscompares++; $display("FAIL mid_gnt: got %b want 00", bus.gnt); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    vectors++; if (p !== 4'b0000) begin miscompares++; $display("FAIL mid_pulses: got %b want 0000", p); end
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i2c);
      if (bus.done0 || bus.err0 || bus.done1 || bus.err1) npulse++;
    end
    vectors++; if (npulse !== 0) begin miscompares++; $display("FAIL mid_no_pulse: got %0d want 0", npulse); end
    bus.req0 = 1'b1;
    wait_pulse(200, cyc, p);
    bus.req0 = 1'b0;
    vectors++; if (p !== 4'b1000) begin miscompares++; $display("FAIL mid_rerequest: got %b want 1000", p); end
    repeat (3) @(negedge clk_i2c);
  endtask

  initial begin
    reset     = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = 24'h0;
    bus.data1 = 24'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_retry();
    test_timeout();
    test_stale_end();
    test_reset_mid();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
